// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the LSU memory stage.
//   funct3 access-size encodings, FSM state type, access-size classification
//   helper, and the data word reported on a memory timeout.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_0000;

  typedef enum logic {
    IDLE,
    MEM_WAIT
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_e;

  // Undefined encodings fall through to word access.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_stage_load_align.sv
// load_align: combinational load-data formatter.
//   rdata_i   [31:0] raw word returned by data memory
//   addr_lo_i [1:0]  byte offset of the access within the word
//   funct3_i  [2:0]  access type (B/H signed, BU/HU unsigned, else word)
//   data_o    [31:0] lane-selected, sign/zero-extended result
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data_o = {24'h0, shifted[7:0]};
      F3_HU:   data_o = {16'h0, shifted[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-access stage after execute.
//   CLK, RST            clock, synchronous active-high reset
//   valid_i / ready_o   upstream handshake (ready only in IDLE)
//   alu_res_i           effective address or pass-through ALU value
//   st_data_i, funct3_i, is_load_i, is_store_i, rd_i  instruction fields
//   mem_req/we/addr/wdata/be, mem_ack/rdata           data-memory req/ack port
//   wb_valid/we/rd/data, misalign_err                 registered writeback result
// Optional build macro LSU_TIMEOUT_EN: abandon a request after TIMEOUT_CYCLES
// cycles without mem_ack and report it as a fault with data TIMEOUT_DATA.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] alu_res_i,
  input  logic [31:0] st_data_i,
  input  logic [2:0]  funct3_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [4:0]  rd_i,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  lsu_state_e  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misalign_q, misalign_d;

  // Context of the outstanding memory access
  logic        ld_q, ld_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lo_q, lo_d;
  logic [4:0]  rd_q, rd_d;

  logic [31:0] ld_data;
  lsu_size_e   size;
  logic [1:0]  a_lo;
  logic        misaligned;
  logic [3:0]  be;
  logic [31:0] wdata;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  load_align u_load_align (
    .rdata_i   (mem_rdata),
    .addr_lo_i (lo_q),
    .funct3_i  (f3_q),
    .data_o    (ld_data)
  );

  assign ready_o = (state_q == IDLE);

  always_comb begin
    size = f3_size(funct3_i);
    a_lo = alu_res_i[1:0];
    misaligned = ((size == SZ_H) && a_lo[0]) ||
                 ((size == SZ_W) && (a_lo != 2'b00));
    case (size)
      SZ_B:    begin be = 4'b0001 << a_lo; wdata = {4{st_data_i[7:0]}};  end
      SZ_H:    begin be = 4'b0011 << a_lo; wdata = {2{st_data_i[15:0]}}; end
      default: begin be = 4'b1111;         wdata = st_data_i;            end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    misalign_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    ld_d        = ld_q;
    f3_d        = f3_q;
    lo_d        = lo_q;
    rd_d        = rd_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (!(is_load_i || is_store_i)) begin
            wb_valid_d = 1'b1;
            wb_we_d    = (rd_i != 5'd0);
            wb_rd_d    = rd_i;
            wb_data_d  = alu_res_i;
          end else if (misaligned) begin
            wb_valid_d = 1'b1;
            misalign_d = 1'b1;
            wb_rd_d    = rd_i;
            wb_data_d  = alu_res_i;
          end else begin
            state_d     = MEM_WAIT;
            mem_req_d   = 1'b1;
            // Load wins when both load and store are flagged
            mem_we_d    = !is_load_i;
            mem_addr_d  = {alu_res_i[31:2], 2'b00};
            mem_be_d    = be;
            mem_wdata_d = wdata;
            ld_d        = is_load_i;
            f3_d        = funct3_i;
            lo_d        = a_lo;
            rd_d        = rd_i;
`ifdef LSU_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_we_d    = ld_q && (rd_q != 5'd0);
          wb_data_d  = ld_q ? ld_data : '0;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          misalign_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = TIMEOUT_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      misalign_q  <= 1'b0;
      ld_q        <= 1'b0;
      f3_q        <= '0;
      lo_q        <= '0;
      rd_q        <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      misalign_q  <= misalign_d;
      ld_q        <= ld_d;
      f3_q        <= f3_d;
      lo_q        <= lo_d;
      rd_q        <= rd_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_be       = mem_be_q;
  assign wb_valid     = wb_valid_q;
  assign wb_we        = wb_we_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed self-checking bench for lsu_mem_stage.
module tb_lsu_mem_stage;

  logic        CLK, RST;
  logic        valid_i, ready_o;
  logic [31:0] alu_res_i, st_data_i;
  logic [2:0]  funct3_i;
  logic        is_load_i, is_store_i;
  logic [4:0]  rd_i;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST), .valid_i(valid_i), .ready_o(ready_o),
    .alu_res_i(alu_res_i), .st_data_i(st_data_i), .funct3_i(funct3_i),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .rd_i(rd_i),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .misalign_err(misalign_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; return at the falling edge where outputs are sampled.
  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Present one instruction for a single accept edge.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd);
    valid_i = 1'b1; is_load_i = ld; is_store_i = st; funct3_i = f3;
    alu_res_i = addr; st_data_i = sd; rd_i = rd;
    cyc();
    valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
  endtask

  // Return an ack with data for one edge.
  task automatic ack(input logic [31:0] rdata);
    mem_ack = 1'b1; mem_rdata = rdata;
    cyc();
    mem_ack = 1'b0;
  endtask

  task automatic check_wb(input string tag, input logic we, input logic [4:0] rd,
                          input logic [31:0] data, input logic err);
    check_eq({tag, ".wb_valid"}, {31'd0, wb_valid}, 32'd1);
    check_eq({tag, ".wb_we"}, {31'd0, wb_we}, {31'd0, we});
    check_eq({tag, ".wb_rd"}, {27'd0, wb_rd}, {27'd0, rd});
    check_eq({tag, ".wb_data"}, wb_data, data);
    check_eq({tag, ".misalign"}, {31'd0, misalign_err}, {31'd0, err});
  endtask

  task automatic check_req(input string tag, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
    check_eq({tag, ".mem_req"}, {31'd0, mem_req}, 32'd1);
    check_eq({tag, ".ready"}, {31'd0, ready_o}, 32'd0);
    check_eq({tag, ".mem_we"}, {31'd0, mem_we}, {31'd0, we});
    check_eq({tag, ".mem_addr"}, mem_addr, addr);
    check_eq({tag, ".mem_be"}, {28'd0, mem_be}, {28'd0, be});
    if (we) check_eq({tag, ".mem_wdata"}, mem_wdata, wd);
  endtask

  initial begin
    RST = 1'b1; valid_i = 1'b0; alu_res_i = '0; st_data_i = '0; funct3_i = '0;
    is_load_i = 1'b0; is_store_i = 1'b0; rd_i = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) cyc();

    // Reset state
    check_eq("rst.ready", {31'd0, ready_o}, 32'd1);
    check_eq("rst.mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst.mem_we", {31'd0, mem_we}, 32'd0);
    check_eq("rst.mem_addr", mem_addr, 32'd0);
    check_eq("rst.mem_wdata", mem_wdata, 32'd0);
    check_eq("rst.mem_be", {28'd0, mem_be}, 32'd0);
    check_eq("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
    check_eq("rst.wb_we", {31'd0, wb_we}, 32'd0);
    check_eq("rst.wb_rd", {27'd0, wb_rd}, 32'd0);
    check_eq("rst.wb_data", wb_data, 32'd0);
    check_eq("rst.misalign", {31'd0, misalign_err}, 32'd0);
    RST = 1'b0;
    cyc();

    // ALU pass-through, then back-to-back with rd=0
    valid_i = 1'b1; alu_res_i = 32'h1234_5678; rd_i = 5'd5;
    cyc();
    check_wb("alu1", 1'b1, 5'd5, 32'h1234_5678, 1'b0);
    check_eq("alu1.mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("alu1.ready", {31'd0, ready_o}, 32'd1);
    alu_res_i = 32'h0BAD_F00D; rd_i = 5'd0;
    cyc();
    check_wb("alu0", 1'b0, 5'd0, 32'h0BAD_F00D, 1'b0);
    valid_i = 1'b0;
    cyc();
    check_eq("alu.pulse", {31'd0, wb_valid}, 32'd0);

    // LB with sign extension, two wait cycles
    issue(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd7);
    check_req("lb", 1'b0, 32'h0000_1000, 4'b1000, 32'h0);
    repeat (2) begin
      cyc();
      check_eq("lb.wait_req", {31'd0, mem_req}, 32'd1);
      check_eq("lb.wait_wbv", {31'd0, wb_valid}, 32'd0);
    end
    ack(32'h80FF_FFFF);
    check_wb("lb", 1'b1, 5'd7, 32'hFFFF_FF80, 1'b0);
    check_eq("lb.req_drop", {31'd0, mem_req}, 32'd0);
    check_eq("lb.ready", {31'd0, ready_o}, 32'd1);
    cyc();
    check_eq("lb.pulse", {31'd0, wb_valid}, 32'd0);

    // SH to upper half
    issue(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hAAAA_BEEF, 5'd9);
    check_req("sh", 1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF);
    ack(32'h0);
    check_wb("sh", 1'b0, 5'd9, 32'h0, 1'b0);

    // SB at offset 1
    issue(1'b0, 1'b1, 3'b000, 32'h0000_5001, 32'h1122_3344, 5'd1);
    check_req("sb", 1'b1, 32'h0000_5000, 4'b0010, 32'h4444_4444);
    ack(32'h0);
    check_wb("sb", 1'b0, 5'd1, 32'h0, 1'b0);

    // LHU / LH on upper half, LBU, LW
    issue(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 5'd3);
    check_req("lhu", 1'b0, 32'h0000_2000, 4'b1100, 32'h0);
    ack(32'h8001_1234);
    check_wb("lhu", 1'b1, 5'd3, 32'h0000_8001, 1'b0);
    issue(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 5'd4);
    ack(32'h8001_1234);
    check_wb("lh", 1'b1, 5'd4, 32'hFFFF_8001, 1'b0);
    issue(1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'h0, 5'd6);
    check_req("lbu", 1'b0, 32'h0000_2000, 4'b0010, 32'h0);
    ack(32'h1234_A5C3);
    check_wb("lbu", 1'b1, 5'd6, 32'h0000_00A5, 1'b0);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd0);
    check_req("lw", 1'b0, 32'h0000_4000, 4'b1111, 32'h0);
    ack(32'hCAFE_F00D);
    check_wb("lw_rd0", 1'b0, 5'd0, 32'hCAFE_F00D, 1'b0);

    // Misaligned LW and LH: no request, fault pulse with address
    issue(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 5'd8);
    check_eq("mis_lw.mem_req", {31'd0, mem_req}, 32'd0);
    check_wb("mis_lw", 1'b0, 5'd8, 32'h0000_3001, 1'b0 | 1'b1);
    issue(1'b1, 1'b0, 3'b001, 32'h0000_3003, 32'h0, 5'd8);
    check_eq("mis_lh.mem_req", {31'd0, mem_req}, 32'd0);
    check_wb("mis_lh", 1'b0, 5'd8, 32'h0000_3003, 1'b1);
    cyc();
    check_eq("mis.pulse", {31'd0, misalign_err}, 32'd0);

    // Undefined funct3 behaves as word: aligned store, then misaligned one
    issue(1'b0, 1'b1, 3'b011, 32'h0000_6000, 32'h89AB_CDEF, 5'd2);
    check_req("f3u", 1'b1, 32'h0000_6000, 4'b1111, 32'h89AB_CDEF);
    ack(32'h0);
    check_wb("f3u", 1'b0, 5'd2, 32'h0, 1'b0);
    issue(1'b0, 1'b1, 3'b110, 32'h0000_6002, 32'h0, 5'd2);
    check_eq("f3u_mis.mem_req", {31'd0, mem_req}, 32'd0);
    check_wb("f3u_mis", 1'b0, 5'd2, 32'h0000_6002, 1'b1);

    // Load and store both set: load wins
    issue(1'b1, 1'b1, 3'b010, 32'h0000_7004, 32'hFFFF_FFFF, 5'd10);
    check_req("ldst", 1'b0, 32'h0000_7004, 4'b1111, 32'h0);
    ack(32'h5555_AAAA);
    check_wb("ldst", 1'b1, 5'd10, 32'h5555_AAAA, 1'b0);

    // mem_ack while idle is ignored
    ack(32'h1111_1111);
    check_eq("idle_ack.wb_valid", {31'd0, wb_valid}, 32'd0);
    check_eq("idle_ack.mem_req", {31'd0, mem_req}, 32'd0);

    // Reset in the middle of a transaction
    issue(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0, 5'd11);
    check_eq("rmid.req_up", {31'd0, mem_req}, 32'd1);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    check_eq("rmid.mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rmid.ready", {31'd0, ready_o}, 32'd1);
    ack(32'h2222_2222);
    check_eq("rmid.wb_valid", {31'd0, wb_valid}, 32'd0);
    cyc();
    check_eq("rmid.wb_valid2", {31'd0, wb_valid}, 32'd0);

    // No ack for a while
    issue(1'b1, 1'b0, 3'b010, 32'h0000_8000, 32'h0, 5'd12);
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      check_eq("tmo.req_held", {31'd0, mem_req}, 32'd1);
      cyc();
    end
    check_eq("tmo.req_last", {31'd0, mem_req}, 32'd1);
    cyc();
    check_eq("tmo.req_drop", {31'd0, mem_req}, 32'd0);
    check_eq("tmo.ready", {31'd0, ready_o}, 32'd1);
    check_wb("tmo", 1'b0, 5'd12, 32'hDEAD_0000, 1'b1);
`else
    for (int i = 0; i < 6; i++) begin
      check_eq("nack.req_held", {31'd0, mem_req}, 32'd1);
      check_eq("nack.wb_valid", {31'd0, wb_valid}, 32'd0);
      cyc();
    end
    ack(32'h0000_00FF);
    check_wb("nack", 1'b1, 5'd12, 32'h0000_00FF, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
